fixed_point_div: RTL

Iterative signed fixed-point divider, the inverse companion of the fixed-point multiplier in the datapath. It computes A/B in the same WIDTH/FRAC_BITS representation and resolves one quotient bit per clock using restoring division on magnitudes. It accepts one operation at a time under a ready/valid handshake and returns a single-cycle result pulse.

---
 rtl/fixed_point_div.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fixed_point_div.sv
// rtl/fixed_point_div.sv - iterative signed fixed-point restoring divider, one quotient bit per clock
// Optional: FIXED_POINT_DIV_SATURATE_EN clamps overflowed quotients instead of wrapping.
module fixed_point_div #(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] VALUE_A_IN,
    input  logic [WIDTH-1:0] VALUE_B_IN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic [WIDTH-1:0] VALUE_OUT,
    output logic             VALID_OUT,
    output logic             OVERFLOW_OUT,
    output logic             DIV_BY_ZERO_OUT
);

    localparam int N  = WIDTH + FRAC_BITS;
    localparam int CW = $clog2(N);

    localparam logic [N-1:0]     POS_MAX = {{(FRAC_BITS + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [N-1:0]     NEG_MAG = {{(FRAC_BITS + 1){1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [N-1:0]     dvd_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] div_q;
    logic             neg_q;
    logic             a_neg_q;
    logic             zero_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic             qbit;
    logic [WIDTH:0]   rem_d;
    logic [N-1:0]     dvd_d;
    logic [N-1:0]     signed_q;
    logic             ovf_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // The dividend register shifts its MSB into the remainder and collects quotient bits at the LSB.
    always_comb begin
        trial    = {rem_q[WIDTH-1:0], dvd_q[N-1]};
        diff     = {1'b0, trial} - {2'b00, div_q};
        qbit     = ~diff[WIDTH+1];
        rem_d    = qbit ? diff[WIDTH:0] : trial;
        dvd_d    = {dvd_q[N-2:0], qbit};
        signed_q = neg_q ? -dvd_d : dvd_d;
        ovf_d    = 1'b0;
        if (!zero_q) begin
            ovf_d = neg_q ? (dvd_d > NEG_MAG) : (dvd_d > POS_MAX);
        end
        result_d = signed_q[WIDTH-1:0];
        if (zero_q) begin
            result_d = a_neg_q ? SAT_NEG : SAT_POS;
        end else if (ovf_d) begin
`ifdef FIXED_POINT_DIV_SATURATE_EN
            result_d = neg_q ? SAT_NEG : SAT_POS;
`else
            result_d = signed_q[WIDTH-1:0];
`endif
        end
    end

    // Most-negative operand negates to itself, which reads correctly as an unsigned magnitude.
    always_comb begin
        abs_a = VALUE_A_IN[WIDTH-1] ? -VALUE_A_IN : VALUE_A_IN;
        abs_b = VALUE_B_IN[WIDTH-1] ? -VALUE_B_IN : VALUE_B_IN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= S_IDLE;
            dvd_q           <= '0;
            rem_q           <= '0;
            div_q           <= '0;
            neg_q           <= 1'b0;
            a_neg_q         <= 1'b0;
            zero_q          <= 1'b0;
            cnt_q           <= '0;
            READY_OUT       <= 1'b1;
            VALID_OUT       <= 1'b0;
            VALUE_OUT       <= '0;
            OVERFLOW_OUT    <= 1'b0;
            DIV_BY_ZERO_OUT <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (VALID_IN) begin
                        dvd_q     <= {abs_a, {FRAC_BITS{1'b0}}};
                        div_q     <= abs_b;
                        neg_q     <= VALUE_A_IN[WIDTH-1] ^ VALUE_B_IN[WIDTH-1];
                        a_neg_q   <= VALUE_A_IN[WIDTH-1];
                        zero_q    <= (VALUE_B_IN == '0);
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        READY_OUT <= 1'b0;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Final step publishes the result on the same edge to keep latency at N.
                    if (cnt_q == CW'(N - 1)) begin
                        VALUE_OUT       <= result_d;
                        OVERFLOW_OUT    <= ovf_d;
                        DIV_BY_ZERO_OUT <= zero_q;
                        VALID_OUT       <= 1'b1;
                        state_q         <= S_DONE;
                    end
                end
                S_DONE: begin
                    VALID_OUT <= 1'b0;
                    READY_OUT <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    READY_OUT <= 1'b1;
                    VALID_OUT <= 1'b0;
                end
            endcase
        end
    end

endmodule
